// File: rtl/dump_seq_pkg.sv
// Shared types and default widths for the dump sequencer.
// Holds the FSM state encoding and default counter widths.
// No logic; imported by dump_seq_ctrl.
package dump_seq_pkg;

  localparam int TMO_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_e;

endpackage

// File: rtl/dump_edge_sync.sv
// Synchronises the asynchronous dumpoff level and detects its edges.
// Latency: level/rise/fall are valid 2 cycles after the input changes, so the FSM acts on the 3rd edge.
// No backpressure; continuous sampling.
module dump_edge_sync (
  input  logic clk_sys,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next values: two metastability stages, then one history stage for edge detection.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and history registers, cleared by asynchronous reset.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;

endmodule

// File: rtl/dump_seq_ctrl.sv
// Runs one dump sequence per go: strobe start, wait for dumpoff high then low, measure high time.
// Latency: state_start one cycle after go; dumpoff edges act 3 cycles after the pin changes.
// go is ignored while busy; optional width measurement under DUMP_WIDTH_MEAS_EN (width tied 0 otherwise).
module dump_seq_ctrl
  import dump_seq_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             go,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             dumpoff,
  output logic             state_start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] width
);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] timer_inc;
  logic             tmo_hit;
  logic             d_lvl, d_rise, d_fall;
  logic             w_clr, w_load, w_inc;

  dump_edge_sync u_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (dumpoff),
    .level   (d_lvl),
    .rise    (d_rise),
    .fall    (d_fall)
  );

  // Timer never wraps; with a zero limit it parks at all-ones and never expires.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TMO_W'(1);
  assign tmo_hit   = (tmo_limit != '0) && (timer_q == tmo_limit - TMO_W'(1));

  // Next-state logic; edges take priority over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    w_clr   = 1'b0;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = START;
          err_d   = 1'b0;
          w_clr   = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_HI;
        timer_d = '0;
      end
      WAIT_HI: begin
        if (d_rise) begin
          state_d = WAIT_LO;
          timer_d = '0;
          w_load  = 1'b1;
        end else if (tmo_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_LO: begin
        if (d_fall) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
          w_inc   = d_lvl;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, timer and sticky error registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign state_start = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;

`ifdef DUMP_WIDTH_MEAS_EN
  logic [CNT_W-1:0] width_q, width_d;

  // Width counter: cleared on accept, loaded with 1 on the rise, saturating count while high.
  always_comb begin
    width_d = width_q;
    if (w_clr) begin
      width_d = '0;
    end else if (w_load) begin
      width_d = CNT_W'(1);
    end else if (w_inc && (width_q != '1)) begin
      width_d = width_q + CNT_W'(1);
    end
  end

  // Width register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      width_q <= '0;
    end else begin
      width_q <= width_d;
    end
  end

  assign width = width_q;
`else
  logic ctl_unused;
  assign ctl_unused = w_clr | w_load | w_inc;
  assign width      = '0;
`endif

endmodule

// File: tb/tb_dump_seq_ctrl.sv
// Directed bench for dump_seq_ctrl: nominal dump, timeouts, edge/timeout ties, ignored go, reset abort, saturation.
// Expected widths follow the DUMP_WIDTH_MEAS_EN build setting.
// Outputs are sampled 1 ns after the rising edge; strobes are counted on the falling edge.
module tb_dump_seq_ctrl;

`ifdef DUMP_WIDTH_MEAS_EN
  localparam int W_EN = 1;
`else
  localparam int W_EN = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        go;
  logic [15:0] tmo_limit;
  logic        dumpoff;
  logic        state_start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] width;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ss_cnt, ss_cyc, done_cnt, done_cyc;
  int g;

  dump_seq_ctrl #(.TMO_W(16), .CNT_W(16)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .go          (go),
    .tmo_limit   (tmo_limit),
    .dumpoff     (dumpoff),
    .state_start (state_start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .width       (width)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!rst) begin
      if (state_start) begin
        ss_cnt = ss_cnt + 1;
        ss_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic clr_mon();
    ss_cnt   = 0;
    ss_cyc   = 0;
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wexp(input int n);
    return (W_EN != 0) ? n : 0;
  endfunction

  initial begin
    rst       = 1'b1;
    go        = 1'b0;
    dumpoff   = 1'b0;
    tmo_limit = 16'd100;
    clr_mon();

    // Reset values.
    tick(3);
    chk("rst_state_start", 32'(state_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_width", 32'(width), 0);
    rst = 1'b0;

    // Nominal: go at 10, dumpoff high 20..49.
    tick(10 - cyc);
    go_pulse();
    tick(20 - cyc);
    dumpoff = 1'b1;
    tick(10);
    chk("nom_busy_mid", 32'(busy), 1);
    tick(20);
    dumpoff = 1'b0;
    tick(10);
    chk("nom_ss_cnt", ss_cnt, 1);
    chk("nom_ss_cyc", ss_cyc, 11);
    chk("nom_done_cnt", done_cnt, 1);
    chk("nom_done_cyc", done_cyc, 53);
    chk("nom_err", 32'(err), 0);
    chk("nom_width", 32'(width), wexp(30));
    chk("nom_busy_end", 32'(busy), 0);

    // Timeout in WAIT_HI, dumpoff never rises.
    clr_mon();
    tmo_limit = 16'd8;
    g = cyc;
    go_pulse();
    tick(15);
    chk("tmo_done_cnt", done_cnt, 1);
    chk("tmo_done_cyc", done_cyc, g + 10);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_width", 32'(width), 0);

    // Rise and fall each coincide with a timeout: edges win.
    clr_mon();
    g = cyc;
    go_pulse();
    tick(6);
    dumpoff = 1'b1;
    tick(8);
    dumpoff = 1'b0;
    tick(10);
    chk("tie_err", 32'(err), 0);
    chk("tie_done_cnt", done_cnt, 1);
    chk("tie_done_cyc", done_cyc, g + 18);
    chk("tie_width", 32'(width), wexp(8));

    // dumpoff already high at WAIT_HI entry is not a rise.
    clr_mon();
    dumpoff = 1'b1;
    tick(5);
    g = cyc;
    go_pulse();
    tick(15);
    chk("pre_err", 32'(err), 1);
    chk("pre_done_cyc", done_cyc, g + 10);
    chk("pre_width", 32'(width), 0);
    dumpoff = 1'b0;
    tick(5);

    // Second go during WAIT_LO is ignored.
    clr_mon();
    tmo_limit = 16'd100;
    g = cyc;
    go_pulse();
    tick(4);
    dumpoff = 1'b1;
    tick(5);
    go_pulse();
    tick(4);
    dumpoff = 1'b0;
    tick(10);
    chk("dbl_ss_cnt", ss_cnt, 1);
    chk("dbl_done_cnt", done_cnt, 1);
    chk("dbl_done_cyc", done_cyc, g + 18);
    chk("dbl_width", 32'(width), wexp(10));
    chk("dbl_err", 32'(err), 0);

    // Reset while in WAIT_LO aborts without done.
    clr_mon();
    g = cyc;
    go_pulse();
    tick(1);
    dumpoff = 1'b1;
    tick(6);
    chk("abt_width_pre", 32'(width), wexp(4));
    chk("abt_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abt_busy", 32'(busy), 0);
    chk("abt_state_start", 32'(state_start), 0);
    chk("abt_done", 32'(done), 0);
    chk("abt_err", 32'(err), 0);
    chk("abt_width", 32'(width), 0);
    dumpoff = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("abt_done_cnt", done_cnt, 0);
    go_pulse();
    tick(3);
    dumpoff = 1'b1;
    tick(5);
    dumpoff = 1'b0;
    tick(10);
    chk("abt2_done_cnt", done_cnt, 1);
    chk("abt2_width", 32'(width), wexp(5));
    chk("abt2_err", 32'(err), 0);

    // No timeout, dumpoff stuck high: width saturates, no done.
    clr_mon();
    tmo_limit = 16'd0;
    go_pulse();
    tick(2);
    dumpoff = 1'b1;
    tick(70000);
    chk("sat_busy", 32'(busy), 1);
    chk("sat_done_cnt", done_cnt, 0);
    chk("sat_width", 32'(width), wexp(65535));
    dumpoff = 1'b0;
    tick(10);
    chk("sat_done_end", done_cnt, 1);
    chk("sat_err_end", 32'(err), 0);
    chk("sat_width_end", 32'(width), wexp(65535));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dump_seq_ctrl.md
DUMP_SEQ_CTRL -- requirements
Module: dump_seq_ctrl

Interface
REQ-001 SHALL have parameter TMO_W, default 16, meaning timeout counter width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, meaning dump pulse-width counter width in bits.
REQ-003 SHALL have port clk_sys  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port go  input  1  single-cycle request to run one dump sequence.
REQ-006 SHALL have port tmo_limit  input  TMO_W  cycles allowed per wait phase; 0 disables timeout.
REQ-007 SHALL have port dumpoff  input  1  dump-off level returned by the dump block, treated as asynchronous.
REQ-008 SHALL have port state_start  output  1  one-cycle start strobe to the dump block.
REQ-009 SHALL have port busy  output  1  high from START through DONE.
REQ-010 SHALL have port done  output  1  one-cycle completion strobe, success or error.
REQ-011 SHALL have port err  output  1  timeout flag, sticky until next accepted go.
REQ-012 SHALL have port width  output  CNT_W  measured dumpoff high time in clk_sys cycles.

Function
REQ-013 SHALL pass dumpoff through a 2-flop synchroniser plus one edge-detect register; rise/fall seen 3 cycles after input change.
REQ-014 SHALL implement FSM states IDLE, START, WAIT_HI, WAIT_LO, DONE.
REQ-015 IDLE: go=1 -> START next cycle; clear err and width on acceptance.
REQ-016 START: state_start=1 exactly this one cycle -> WAIT_HI; go at cycle N gives state_start at N+1.
REQ-017 WAIT_HI: timer counts from 0 each cycle; synced rise -> WAIT_LO with width=1.
REQ-018 WAIT_LO: width increments each cycle synced dumpoff high, saturating at all-ones; synced fall -> DONE.
REQ-019 Timer SHALL restart at 0 on entering WAIT_HI and WAIT_LO; if tmo_limit!=0 and timer==tmo_limit-1, set err=1 and go to DONE.
REQ-020 DONE: done=1 one cycle -> IDLE; width and err hold until next accepted go.
REQ-021 go while busy SHALL be ignored, not queued.
REQ-022 Rise and timeout in the same cycle: rise wins; fall and timeout same cycle: fall wins, err stays 0.
REQ-023 dumpoff already high when WAIT_HI entered SHALL not count as rise; a fresh low-to-high edge is required.
REQ-024 Timer SHALL not wrap; with tmo_limit=0 it saturates at all-ones and never expires.

Reset
REQ-025 rst SHALL asynchronously force FSM to IDLE, synchroniser flops to 0, state_start=0, busy=0, done=0, err=0, width=0.
REQ-026 rst mid-sequence SHALL abort without a done strobe; first go after release starts a clean sequence.

Configuration
REQ-027 With DUMP_WIDTH_MEAS_EN defined, width counter and port behave per REQ-018.
REQ-028 Without DUMP_WIDTH_MEAS_EN, width port SHALL be tied 0, counter omitted; WAIT_LO still waits for fall and timeout.

Structure
REQ-029 Package dump_seq_pkg SHALL hold the FSM state enum typedef and default TMO_W/CNT_W constants.
REQ-030 Synchroniser and edge detector SHALL be one sub-module dump_edge_sync (outputs level, rise, fall).

Verification
REQ-031 go at cycle 10, dumpoff high cycles 20-49 (30 cycles), tmo_limit=100 -> state_start at 11, done once, err=0, width=30.
REQ-032 go, dumpoff never rises, tmo_limit=8 -> done 8 cycles after WAIT_HI entry, err=1, width=0.
REQ-033 dumpoff rises, never falls, tmo_limit=0, 70000 cycles, CNT_W=16 -> busy stays 1, width saturates at 65535, no done.
REQ-034 Second go during WAIT_LO -> ignored: one state_start, one done.
REQ-035 rst asserted in WAIT_LO -> all outputs 0 immediately, no done; later go with 5-cycle pulse -> width=5.
REQ-036 Build without DUMP_WIDTH_MEAS_EN, rerun REQ-031 -> width=0, done and timing unchanged.
